// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Brief    : Shared state encodings, default widths and parity constants for
//            the UART receive controller.
// Revision : 1.0
// ============================================================================
package uart_rx_pkg;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_PRESCALE_WIDTH = 5;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_edge_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_edge_bit_counter
// Brief    : Oversampling edge counter with end-of-bit strobe and a data-bit
//            counter advanced on every end-of-bit.
// Revision : 1.0
// ============================================================================
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      enable_i,
    input  logic                      edge_clr_i,
    input  logic                      bit_clr_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic [PRESCALE_WIDTH-1:0] edge_count_o,
    output logic                      end_of_bit_o,
    output logic [BIT_CNT_WIDTH-1:0]  bit_count_o
);

    logic [PRESCALE_WIDTH-1:0] edge_q;
    logic [BIT_CNT_WIDTH-1:0]  bit_q;
    logic [PRESCALE_WIDTH-1:0] last_edge;

    assign last_edge    = prescale_i - PRESCALE_WIDTH'(1);
    assign end_of_bit_o = enable_i && !edge_clr_i && (edge_q == last_edge);
    assign edge_count_o = edge_q;
    assign bit_count_o  = bit_q;

    // A disabled counter sits at zero so the first enabled cycle is edge 0.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            if (!enable_i || edge_clr_i || end_of_bit_o) begin
                edge_q <= '0;
            end else begin
                edge_q <= edge_q + PRESCALE_WIDTH'(1);
            end

            if (bit_clr_i) begin
                bit_q <= '0;
            end else if (end_of_bit_o) begin
                bit_q <= bit_q + BIT_CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : UART receive controller around the RX data sampler: start check,
//            LSB-first deserialisation, optional parity and stop checks.
//            Optional break detection via UART_RX_BREAK_DETECT_EN.
// Revision : 1.0
// ============================================================================
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      S_Data,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      sampled,
    input  logic                      Sampled_bit,
    output logic [PRESCALE_WIDTH-1:0] edge_count,
    output logic                      S_EN,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      Data_Valid,
    output logic                      Par_err,
    output logic                      Stop_err
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                      Break_det
`endif
);

    localparam int                     BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT    = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    rx_state_e                 state_q;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic                      par_fail_q;

    logic                      start_block;
    logic                      start_edge;
    logic                      false_start;
    logic                      end_of_bit;
    logic [BIT_CNT_WIDTH-1:0]  bit_count;

    assign start_edge  = (state_q == IDLE) && !S_Data && !start_block;
    assign S_EN        = (state_q != IDLE) || start_edge;
    assign false_start = (state_q == START) && sampled && Sampled_bit;

    uart_rx_edge_bit_counter #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
    ) u_counter (
        .CLK          (CLK),
        .Reset        (Reset),
        .enable_i     (S_EN),
        .edge_clr_i   (false_start),
        .bit_clr_i    (state_q != DATA),
        .prescale_i   (prescale_q),
        .edge_count_o (edge_count),
        .end_of_bit_o (end_of_bit),
        .bit_count_o  (bit_count)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_fail_q <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_err    <= 1'b0;
            Stop_err   <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_q    <= START;
                        prescale_q <= Prescale;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        par_fail_q <= 1'b0;
                        Par_err    <= 1'b0;
                        Stop_err   <= 1'b0;
                    end
                end
                START: begin
                    if (false_start) begin
                        state_q <= IDLE;
                    end else if (end_of_bit) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (sampled) begin
                        shift_q <= {Sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    end
                    if (end_of_bit && (bit_count == LAST_BIT)) begin
                        state_q <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (sampled) begin
                        par_fail_q <= Sampled_bit ^ (^shift_q) ^ (par_typ_q == PAR_ODD);
                    end
                    if (end_of_bit) begin
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (sampled) begin
                        Stop_err <= ~Sampled_bit;
                        Par_err  <= par_en_q & par_fail_q;
                        if (Sampled_bit && !(par_en_q && par_fail_q)) begin
                            P_DATA     <= shift_q;
                            Data_Valid <= 1'b1;
                        end
                    end
                    // Leaving on the last edge lets a start bit follow with no gap.
                    if (end_of_bit) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic                      brk_now;
    logic                      brk_seen_q;
    logic                      brk_wait_q;
    logic [PRESCALE_WIDTH-1:0] brk_idle_q;
    logic [PRESCALE_WIDTH-1:0] brk_last;

    assign brk_now     = (state_q == STOP) && sampled && !Sampled_bit && (shift_q == '0);
    assign brk_last    = prescale_q - PRESCALE_WIDTH'(1);
    assign start_block = brk_wait_q;

    // After a break the line must rest high for a full bit before re-arming.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            Break_det  <= 1'b0;
            brk_seen_q <= 1'b0;
            brk_wait_q <= 1'b0;
            brk_idle_q <= '0;
        end else begin
            Break_det <= brk_now;
            if (brk_now) begin
                brk_seen_q <= 1'b1;
            end
            if ((state_q == STOP) && end_of_bit) begin
                brk_seen_q <= 1'b0;
                if (brk_seen_q || brk_now) begin
                    brk_wait_q <= 1'b1;
                    brk_idle_q <= '0;
                end
            end else if ((state_q == IDLE) && brk_wait_q) begin
                if (!S_Data) begin
                    brk_idle_q <= '0;
                end else if (brk_idle_q == brk_last) begin
                    brk_wait_q <= 1'b0;
                    brk_idle_q <= '0;
                end else begin
                    brk_idle_q <= brk_idle_q + PRESCALE_WIDTH'(1);
                end
            end
        end
    end
`else
    assign start_block = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Brief    : Self-checking bench for uart_rx_ctrl with a behavioural sampler
//            and a frame-level reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam int PW = 5;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          S_Data;
    logic [PW-1:0] Prescale;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          sampled;
    logic          Sampled_bit;
    logic [PW-1:0] edge_count;
    logic          S_EN;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          Par_err;
    logic          Stop_err;

    int            bench_p = 8;
    int            n_checks = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            dv_count = 0;
    int            dv_cyc[$];
    logic [DW-1:0] dv_data[$];
    logic [DW-1:0] exp_pdata;

    always #5 CLK = ~CLK;

    // Line is constant within a bit, so the majority vote is the line value.
    assign sampled     = S_EN && (int'(edge_count) == bench_p / 2);
    assign Sampled_bit = S_Data;

    uart_rx_ctrl #(
        .DATA_WIDTH     (DW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .S_Data      (S_Data),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled     (sampled),
        .Sampled_bit (Sampled_bit),
        .edge_count  (edge_count),
        .S_EN        (S_EN),
        .P_DATA      (P_DATA),
        .Data_Valid  (Data_Valid),
        .Par_err     (Par_err),
        .Stop_err    (Stop_err)
    );

    always @(negedge CLK) begin
        cyc++;
        if (Data_Valid) begin
            dv_count++;
            dv_cyc.push_back(cyc);
            dv_data.push_back(P_DATA);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int p);
        S_Data = b;
        repeat (p) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic idle(input int n);
        S_Data = 1'b1;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic run_frame(input logic [DW-1:0] d, input int p, input logic pen,
                             input logic typ, input logic pb, input logic sb,
                             input logic scramble);
        logic exp_perr;
        logic exp_serr;
        logic exp_valid;
        bench_p  = p;
        Prescale = PW'(p);
        PAR_EN   = pen;
        PAR_TYP  = typ;
        dv_count = 0;
        drive_bit(1'b0, p);
        if (scramble) begin
            Prescale = PW'($urandom_range(5, 31));
            PAR_EN   = 1'($urandom);
            PAR_TYP  = 1'($urandom);
        end
        for (int i = 0; i < DW; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pb, p);
        drive_bit(sb, p);

        exp_perr  = pen && (pb != ((^d) ^ typ));
        exp_serr  = !sb;
        exp_valid = !exp_perr && !exp_serr;
        if (exp_valid) exp_pdata = d;
        check_eq("dv_pulses", dv_count, {31'b0, exp_valid});
        check_eq("p_data", {24'b0, P_DATA}, {24'b0, exp_pdata});
        check_eq("par_err", {31'b0, Par_err}, {31'b0, exp_perr});
        check_eq("stop_err", {31'b0, Stop_err}, {31'b0, exp_serr});
        if (exp_valid && dv_data.size() > 0)
            check_eq("dv_byte", {24'b0, dv_data[dv_data.size()-1]}, {24'b0, d});
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_pdata"}, {24'b0, P_DATA}, {24'b0, exp_pdata});
        check_eq({tag, "_dv"}, {31'b0, Data_Valid}, 32'd0);
        check_eq({tag, "_par"}, {31'b0, Par_err}, 32'd0);
        check_eq({tag, "_stop"}, {31'b0, Stop_err}, 32'd0);
        check_eq({tag, "_edge"}, {27'b0, edge_count}, 32'd0);
        check_eq({tag, "_sen"}, {31'b0, S_EN}, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          rpen;
        logic          rtyp;
        int            rp;
        Reset     = 1'b0;
        S_Data    = 1'b1;
        Prescale  = PW'(8);
        PAR_EN    = 1'b0;
        PAR_TYP   = 1'b0;
        exp_pdata = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_quiet("reset");
        Reset = 1'b1;
        idle(3);

        run_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        run_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(4);
        run_frame(8'h01, 5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);
        run_frame(8'h80, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Start glitch: two low edges, line back high before mid-bit.
        bench_p  = 8;
        Prescale = PW'(8);
        PAR_EN   = 1'b0;
        dv_count = 0;
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 3);
        check_quiet("glitch");
        idle(10);
        check_eq("glitch_dv", dv_count, 32'd0);

        run_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (dv_cyc.size() >= 2)
            check_eq("b2b_gap", dv_cyc[dv_cyc.size()-1] - dv_cyc[dv_cyc.size()-2], 32'd80);
        else
            check_eq("b2b_pulses", dv_cyc.size(), 32'd2);
        idle(4);

        // Asynchronous reset in the middle of the data bits.
        bench_p  = 8;
        Prescale = PW'(8);
        PAR_EN   = 1'b0;
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 3);
        #3;
        Reset  = 1'b0;
        S_Data = 1'b1;
        exp_pdata = '0;
        #1;
        check_quiet("midrst");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        idle(3);
        run_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        for (int k = 0; k < 24; k++) begin
            rd   = DW'($urandom);
            rp   = $urandom_range(5, 31);
            rpen = 1'($urandom);
            rtyp = 1'($urandom);
            run_frame(rd, rp, rpen, rtyp,
                      ((^rd) ^ rtyp) ^ ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 4) != 0, 1'b1);
            idle($urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
